// File: rtl/mult_seq_if.sv
// Execute-stage bus between the decoder side and the MULTU/MFHI/MFLO unit.
interface mult_seq_if #(
  parameter int unsigned WIDTH = 32
);

  // Decoder-side controls and operands
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mf_req;
  logic             mf_high;
  logic             flush;

  // Multiplier-side results and status
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  // Pipeline / decoder side
  modport master (
    output start, op_a, op_b, mf_req, mf_high, flush,
    input  mf_data, hi, lo, busy, stall, done
  );

  // Multiplier side
  modport slave (
    input  start, op_a, op_b, mf_req, mf_high, flush,
    output mf_data, hi, lo, busy, stall, done
  );

endinterface

// File: rtl/mult_seq.sv
// Radix-2 shift-add unsigned multiplier with HI/LO register file for MULTU/MFHI/MFLO.
// One iteration per cycle; the product lands in HI/LO WIDTH cycles after an accepted start.
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  mult_seq_if.slave   bus
);

  localparam int unsigned CntW  = $clog2(WIDTH) + 1;
  localparam int unsigned ProdW = 2 * WIDTH + 1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [ProdW-1:0]   prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH:0]     sum;
  logic [ProdW-1:0]   prod_shift;
  logic               last_iter;
  logic               accept;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole product right by one.
  // The upper half is WIDTH+1 bits so the carry of the add is kept.
  always_comb begin
    sum        = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_shift = {1'b0, sum, prod_q[WIDTH-1:1]};
    last_iter  = (cnt_q == CntW'(WIDTH - 1));
    accept     = bus.start & ~bus.flush;
  end

  // Control FSM, datapath registers and HI/LO file share one clocked block so
  // every output of the unit is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A start that coincides with a flush belongs to a squashed instruction.
          if (accept) begin
            mcand_q <= bus.op_a;
            prod_q  <= {{(WIDTH + 1){1'b0}}, bus.op_b};
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (bus.flush) begin
            // Abort: HI/LO keep the last completed product, no done pulse.
            state_q <= StIdle;
          end else begin
            prod_q <= prod_shift;
            cnt_q  <= cnt_q + CntW'(1);
            if (last_iter) begin
              hi_q    <= prod_shift[2*WIDTH-1:WIDTH];
              lo_q    <= prod_shift[WIDTH-1:0];
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered status and results; the read mux and the hazard stall are
  // combinational so the pipeline sees them in the same cycle.
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state_q == StBusy);
  assign bus.done    = done_q;
  assign bus.mf_data = bus.mf_high ? hi_q : lo_q;
  assign bus.stall   = (state_q == StBusy) & (bus.start | bus.mf_req);

  // The iteration counter never runs past the final step.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StBusy) |-> (cnt_q < CntW'(WIDTH)));

  // done only ever follows a busy cycle and never overlaps busy.
  a_done_after_busy: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> (state_q == StIdle));

  // The top product bit is always cleared by the shift.
  a_prod_msb: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StBusy) |-> !prod_q[2*WIDTH]);

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: stimulus queues expected {hi,lo}, a monitor
// pops on every done pulse; directed checks cover timing, stall and flush.
module tb_mult_seq;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_without_start", {63'b0, bus.done}, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", {bus.hi, bus.lo}, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] prod, input string tag);
    int n;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    exp_q.push_back(prod);
    tick();
    bus.start = 1'b0;
    count_busy(n);
    check({tag, "_busy_cycles"}, 64'(n), 64'd32);
    check({tag, "_done"}, {63'b0, bus.done}, 64'd1);
    tick();
    check({tag, "_done_single"}, {63'b0, bus.done}, 64'd0);
  endtask

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.mf_req  = 1'b0;
    bus.mf_high = 1'b0;
    bus.flush   = 1'b0;

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_hi", {32'b0, bus.hi}, 64'd0);
    check("rst_lo", {32'b0, bus.lo}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_stall", {63'b0, bus.stall}, 64'd0);
    check("rst_mf_lo", {32'b0, bus.mf_data}, 64'd0);
    bus.mf_high = 1'b1;
    #1;
    check("rst_mf_hi", {32'b0, bus.mf_data}, 64'd0);
    bus.mf_high = 1'b0;

    // Basic and maximum-operand multiplies
    run_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F, "basic");
    check("basic_lo", {32'b0, bus.lo}, 64'h0F);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");

    // Read hazard: MFHI five cycles into a multiply
    bus.op_a  = 32'h0001_0000;
    bus.op_b  = 32'h0001_0000;
    bus.start = 1'b1;
    exp_q.push_back(64'h0000_0001_0000_0000);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.mf_req  = 1'b1;
    bus.mf_high = 1'b1;
    #1;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.stall === 1'b1) n++;
      tick();
    end
    check("hazard_stall_cycles", 64'(n), 64'd27);
    check("hazard_stall_release", {63'b0, bus.stall}, 64'd0);
    check("hazard_mf_data", {32'b0, bus.mf_data}, 64'd1);
    bus.mf_req  = 1'b0;
    bus.mf_high = 1'b0;
    tick();

    // Flush aborts 2x2 and leaves 7x9 in HI/LO
    run_mult(32'd7, 32'd9, 64'h0000_0000_0000_003F, "pre_flush");
    bus.op_a  = 32'd2;
    bus.op_b  = 32'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", {63'b0, bus.busy}, 64'd0);
    check("flush_done", {63'b0, bus.done}, 64'd0);
    check("flush_lo", {32'b0, bus.lo}, 64'h3F);
    check("flush_hi", {32'b0, bus.hi}, 64'd0);
    tick();
    check("flush_no_done", {63'b0, bus.done}, 64'd0);

    // Start while busy is held off, then accepted after done
    bus.op_a  = 32'd4;
    bus.op_b  = 32'd6;
    bus.start = 1'b1;
    exp_q.push_back(64'd24);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == 4) begin
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd100;
        bus.start = 1'b1;
        exp_q.push_back(64'd10000);
        #1;
        check("midop_stall", {63'b0, bus.stall}, 64'd1);
      end
      tick();
    end
    check("midop_busy_cycles", 64'(n), 64'd32);
    check("midop_done", {63'b0, bus.done}, 64'd1);
    check("midop_stall_release", {63'b0, bus.stall}, 64'd0);
    // start and mf_req together in IDLE: read sees the current LO
    bus.mf_req  = 1'b1;
    bus.mf_high = 1'b0;
    #1;
    check("start_mf_lo", {32'b0, bus.mf_data}, 64'd24);
    tick();
    bus.start  = 1'b0;
    bus.mf_req = 1'b0;
    count_busy(n);
    check("second_busy_cycles", 64'(n), 64'd32);
    check("second_done", {63'b0, bus.done}, 64'd1);
    tick();

    // Reset mid-multiply
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, bus.busy}, 64'd0);
    check("midrst_hi", {32'b0, bus.hi}, 64'd0);
    check("midrst_lo", {32'b0, bus.lo}, 64'd0);
    check("midrst_done", {63'b0, bus.done}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("postrst_busy", {63'b0, bus.busy}, 64'd0);
    check("postrst_done", {63'b0, bus.done}, 64'd0);
    run_mult(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "postrst");

    tick();
    check("pending_products", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Sequential unsigned multiplier controller and HI/LO register file for the pipelined MIPS core. It executes MULTU as a radix-2 shift-add operation over WIDTH cycles and holds the 2×WIDTH-bit product in HI/LO. It serves MFHI/MFLO reads and raises a pipeline stall while a read or a new MULTU would hit an in-flight multiply. It sits in the execute stage, driven by the decoder's mult_enable / sfmux_high / sf2reg controls.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  MULTU issued this cycle (decoder mult_enable, qualified by the execute-stage valid bit).
- op_a  in  WIDTH  multiplicand (rs value), sampled only on an accepted start.
- op_b  in  WIDTH  multiplier (rt value), sampled only on an accepted start.
- mf_req  in  1  MFHI/MFLO in execute (decoder sf2reg).
- mf_high  in  1  1 = read HI, 0 = read LO (decoder sfmux_high).
- flush  in  1  execute-stage flush; aborts an in-flight multiply.
- mf_data  out  WIDTH  combinational: mf_high ? hi : lo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multiply in progress (state BUSY).
- stall  out  1  combinational: busy & (start | mf_req).
- done  out  1  one-cycle pulse in the cycle after HI/LO are written.

## Operation
- States: IDLE and BUSY. Iteration counter cnt is $clog2(WIDTH)+1 bits wide.
- IDLE with start=1 and flush=0:
  - Latch mcand=op_a.
  - Load product register P (2·WIDTH+1 bits) with {0, op_b}.
  - Set cnt=0 and go to BUSY.
- IDLE with start=1 and flush=1: the start is ignored.
- BUSY, each cycle:
  - Compute t = P[2W:W] + (P[0] ? mcand : 0), a (WIDTH+1)-bit sum with no overflow loss.
  - Load P = {t, P[W-1:0]} >> 1 and increment cnt.
- BUSY with cnt = WIDTH-1:
  - After the final iteration's shift, write hi = P[2W-1:W] and lo = P[W-1:0].
  - Go to IDLE and set done=1 for the next cycle.
- BUSY with flush=1 (including the final cycle): go to IDLE, leave hi/lo unchanged, no done pulse.
- start while BUSY:
  - Not accepted; stall=1 holds the instruction in execute.
  - It is accepted in the first IDLE cycle, where stall=0.
- mf_req while BUSY: stall=1 until the multiply completes. The first IDLE cycle returns the new product with stall=0.
- mf_req in IDLE: no stall; mf_data returns the current HI or LO.
- start and mf_req together in IDLE: start is accepted and mf_data reflects the old HI/LO. The decoder never produces this case; the bench checks it only for determinism.
- Reset (asserted at any time, including mid-multiply):
  - State IDLE, cnt=0, P=0, mcand=0.
  - hi=0, lo=0, busy=0, done=0.
  - stall and mf_data then follow their combinational definitions.

## Timing
- Start accepted at edge E0: busy=1 from E0 through edge E0+WIDTH.
- HI/LO are written at edge E0+WIDTH. busy=0 and done=1 for the cycle after that edge.
- Latency from accepted start to valid HI/LO is WIDTH cycles (32 at default).
- Back-to-back MULTU: the second start is accepted at edge E0+WIDTH+1 at the earliest.
- stall and mf_data are purely combinational and have no cycle delay.
- Outputs hi, lo, busy and done are registered.

## Test plan
- Reset: hold rst_n=0 for 3 cycles then release. Expect hi=0, lo=0, busy=0, done=0, stall=0, and mf_data=0 for both mf_high values.
- Basic multiply: start with op_a=3, op_b=5 at edge E0. Expect busy=1 for exactly 32 cycles, then lo=0x0000000F, hi=0, and a single done pulse.
- Maximum operands: op_a=op_b=0xFFFFFFFF. Expect hi=0xFFFFFFFE and lo=0x00000001 after 32 cycles.
- Read hazard: issue MFHI (mf_req=1, mf_high=1) 5 cycles after a start of 0x10000 × 0x10000.
  - stall=1 for the remaining 27 busy cycles.
  - Then stall=0 with mf_data=0x00000001.
- Flush: set hi/lo from a previous multiply of 7×9. Start 2×2, then assert flush at cycle 10 of BUSY.
  - busy=0 next cycle, no done pulse.
  - lo stays 0x3F.
- Mid-op events: assert start while BUSY and check stall=1 with no restart; the operation is accepted after done. Separately, pull rst_n low mid-multiply and check all outputs reset immediately with no done pulse.
